// File: rtl/mioc_odrv_n.sv
// rtl/mioc_odrv_n.sv - multi-channel open-drain output driver with pad readback fault detection
module mioc_odrv_n #(
   parameter int N         = 4,
   parameter int SETTLE    = 3,
   parameter int FAULT_LIM = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in,
   input  logic         en,
   input  logic [N-1:0] pad_in,
   input  logic         fault_clr,
   output logic [N-1:0] pad_oe,
   output logic [N-1:0] z,
   output logic [N-1:0] fault,
   output logic         busy
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [3:0] MIS_LIM     = 4'(FAULT_LIM);

   typedef enum logic [1:0] {
      ST_REL = 2'd0,
      ST_SET = 2'd1,
      ST_CHK = 2'd2,
      ST_FLT = 2'd3
   } state_t;

   state_t       r_state    [N];
   state_t       w_state_nxt[N];
   logic [7:0]   r_scnt     [N];
   logic [7:0]   w_scnt_nxt [N];
   logic [3:0]   r_mcnt     [N];
   logic [3:0]   w_mcnt_nxt [N];

   logic [N-1:0] r_sync1;
   logic [N-1:0] r_sync2;
   logic [N-1:0] r_oe;
   logic [N-1:0] r_fault;
   logic         r_busy;

   logic [N-1:0] w_oe_nxt;
   logic [N-1:0] w_fault_nxt;
   logic         w_busy_nxt;

   // Two-flop synchronizer on the raw pad level; idles high like the external pullup
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= pad_in;
         r_sync2 <= r_sync1;
      end
   end

   // Per-channel next-state, counters and the output values they imply
   always_comb begin
      w_busy_nxt  = 1'b0;
      w_oe_nxt    = '0;
      w_fault_nxt = '0;
      for (int i = 0; i < N; i++) begin
         w_state_nxt[i] = r_state[i];
         w_scnt_nxt[i]  = r_scnt[i];
         w_mcnt_nxt[i]  = r_mcnt[i];
         case (r_state[i])
            ST_REL: begin
               w_scnt_nxt[i] = 8'd0;
               w_mcnt_nxt[i] = 4'd0;
               if (en && in[i]) begin
                  w_state_nxt[i] = ST_SET;
               end
            end
            ST_SET: begin
               if (!en || !in[i]) begin
                  w_state_nxt[i] = ST_REL;
                  w_scnt_nxt[i]  = 8'd0;
                  w_mcnt_nxt[i]  = 4'd0;
               end else if (r_scnt[i] == SETTLE_LAST) begin
                  w_state_nxt[i] = ST_CHK;
                  w_scnt_nxt[i]  = 8'd0;
                  w_mcnt_nxt[i]  = 4'd0;
               end else begin
                  w_scnt_nxt[i] = r_scnt[i] + 8'd1;
               end
            end
            ST_CHK: begin
               if (!en || !in[i]) begin
                  w_state_nxt[i] = ST_REL;
                  w_scnt_nxt[i]  = 8'd0;
                  w_mcnt_nxt[i]  = 4'd0;
               end else if (r_sync2[i]) begin
                  // Pad still reads high while we pull it low: something is fighting us
                  if ((r_mcnt[i] + 4'd1) == MIS_LIM) begin
                     w_state_nxt[i] = ST_FLT;
                     w_mcnt_nxt[i]  = 4'd0;
                  end else begin
                     w_mcnt_nxt[i] = r_mcnt[i] + 4'd1;
                  end
               end else begin
                  w_mcnt_nxt[i] = 4'd0;
               end
            end
            ST_FLT: begin
               // Only an explicit clear leaves the fault; in and en are ignored here
               if (fault_clr) begin
                  w_state_nxt[i] = ST_REL;
               end
            end
            default: begin
               w_state_nxt[i] = ST_REL;
            end
         endcase
         w_oe_nxt[i]    = (w_state_nxt[i] == ST_SET) || (w_state_nxt[i] == ST_CHK);
         w_fault_nxt[i] = (w_state_nxt[i] == ST_FLT);
         w_busy_nxt     = w_busy_nxt | (w_state_nxt[i] == ST_SET);
      end
   end

   // State, counters and registered outputs; reset releases every pad at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            r_state[i] <= ST_REL;
            r_scnt[i]  <= 8'd0;
            r_mcnt[i]  <= 4'd0;
         end
         r_oe    <= '0;
         r_fault <= '0;
         r_busy  <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_scnt[i]  <= w_scnt_nxt[i];
            r_mcnt[i]  <= w_mcnt_nxt[i];
         end
         r_oe    <= w_oe_nxt;
         r_fault <= w_fault_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign pad_oe = r_oe;
   assign z      = r_sync2;
   assign fault  = r_fault;
   assign busy   = r_busy;

endmodule

// File: doc/mioc_odrv_n.md
MIOC_ODRV_N -- requirements
Module: mioc_odrv_n

Interface
REQ-001 Parameter N, default 4: number of open-drain channels, legal range 1..32.
REQ-002 Parameter SETTLE, default 3: number of cycles a channel drives low before it checks the pad, legal range 1..255.
REQ-003 Parameter FAULT_LIM, default 2: number of consecutive mismatch cycles that declare a fault, legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in  input  N  drive request; bit i = 1 requests that pad i be pulled low (inverting, open-drain sense).
REQ-007 en  input  1  global enable; 0 releases every channel that is not in fault.
REQ-008 pad_in  input  N  raw pad level read back; asynchronous to clk.
REQ-009 fault_clr  input  1  single-cycle pulse that clears every fault.
REQ-010 pad_oe  output  N  nmos gate control; 1 = pull pad low, 0 = release (external pullup).
REQ-011 z  output  N  synchronized pad level (wired-AND bus value).
REQ-012 fault  output  N  sticky per-channel fault flag.
REQ-013 busy  output  1  1 while any channel is in SET.

Function
REQ-014 pad_in shall pass through a 2-flop synchronizer per bit; z shall be the second flop, giving 2 cycles of latency.
REQ-015 Each channel shall run an independent 4-state FSM: REL (released), SET (driving low, settle count running), CHK (driving low, compare active), FLT (forced release, faulted).
REQ-016 pad_oe[i] shall be registered: 1 in SET and CHK, 0 in REL and FLT.
REQ-017 REL -> SET on the edge where en=1 and in[i]=1; pad_oe[i] rises 1 cycle after the request is sampled.
REQ-018 In SET, an 8-bit per-channel counter shall count from 0; the channel moves SET -> CHK on the edge where the count reaches SETTLE-1, so SET lasts exactly SETTLE cycles.
REQ-019 In SET or CHK, if en=0 or in[i]=0 the channel shall go to REL on that edge; the settle and mismatch counters shall clear.
REQ-020 In CHK, z[i]=1 is a mismatch: the 4-bit mismatch counter increments; z[i]=0 clears the counter.
REQ-021 On the edge where the mismatch counter would reach FAULT_LIM, the channel shall enter FLT, and fault[i] shall become 1 with pad_oe[i]=0 in the same cycle.
REQ-022 FLT shall ignore in and en; FLT -> REL only on fault_clr=1, and fault[i] clears on that same edge.
REQ-023 If fault_clr=1 on the same edge a channel would enter FLT, fault entry shall win and the flag is set.
REQ-024 In REL with en=1 and in[i]=1 held, a return from FLT shall re-enter SET on the next edge (retry).
REQ-025 A pad held low by another device while the channel is in REL shall not be a fault; z[i] simply reads 0.
REQ-026 busy shall be the registered OR of (state == SET) across all channels.
REQ-027 Channels shall not interact; simultaneous events on different channels shall be handled independently in the same cycle.

Reset
REQ-028 While rst_n=0: all FSMs in REL, counters 0, pad_oe=0, fault=0, busy=0, synchronizer flops and z all ones (pullup idle level).
REQ-029 Assertion of rst_n mid-drive or in FLT shall release the pad immediately (asynchronously) and clear fault; the block leaves reset on the first edge after rst_n rises.

Verification (N=4, SETTLE=3, FAULT_LIM=2)
REQ-030 Reset: rst_n=0 with in=4'hF and en=1 -> pad_oe=0, z=4'hF, fault=0, busy=0 throughout.
REQ-031 Normal drive: in[0]=1 sampled at edge k, bench model pulls pad_in[0] low when pad_oe[0]=1 -> pad_oe[0]=1 from k+1, busy=1 for k+1..k+3, CHK from k+4, z[0]=0 from k+3, fault stays 0.
REQ-032 Stuck-high fault: same as REQ-031 but pad_in[0] held 1 -> mismatches at k+4 and k+5, FLT with fault[0]=1 and pad_oe[0]=0 from k+6.
REQ-033 Clear and retry: after REQ-032, fault_clr pulse with in[0]=1 held -> fault[0]=0 on the next edge, SET one edge later; fault_clr coincident with the entry edge -> fault[0] stays 1.
REQ-034 Abort and wired-AND: drop en during SET -> REL on the next edge, counters 0; external pull of pad_in[2] low with in[2]=0 -> z[2]=0 after 2 cycles, fault[2]=0.
REQ-035 Reset mid-operation: rst_n pulsed low while channels 1 and 3 are in CHK and FLT -> pad_oe=0 and fault=0 immediately; normal operation resumes after release.
